// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared encodings and constants for the SHA-256 block padder
package sha256_pkg;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_SLOT    = 56;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  // Padder sequencing states
  typedef enum logic [2:0] {
    FILL,
    PAD,
    ZERO,
    LEN,
    ISSUE,
    DROP,
    WAIT
  } state_t;

  // Where to resume once the core has accepted the current block
  typedef enum logic [1:0] {
    AFTER_FILL,
    AFTER_PAD,
    AFTER_ZERO,
    AFTER_DONE
  } after_t;

  // MSB of byte slot idx; slot 0 sits at [511:504] (i.e. 511 - 8*idx)
  function automatic logic [8:0] slot_msb(input logic [5:0] idx);
    return {~idx, 3'b111};
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - byte-stream to padded 512-bit block front end for sha256_core (optional SHA256_PADDER_BLKCNT_EN)
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64,
  parameter bit MODE  = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         core_init,
  output logic         core_next,
  output logic         core_mode,
  output logic [511:0] core_block,
  input  logic         core_ready,
  output logic         msg_done,
  output logic [15:0]  blk_cnt
);

  localparam logic [5:0] LAST_IDX = 6'(BLOCK_BYTES - 1);
  localparam logic [5:0] LEN_IDX  = 6'(LEN_SLOT);

  state_t             state_q, state_d;
  after_t             after_q, after_d;
  logic [511:0]       blk_q;
  logic [5:0]         idx_q;
  logic [LEN_W-1:0]   len_q;
  logic               first_q;
  logic               armed_q;
  logic               init_q;
  logic               next_q;
  logic               done_q;
  logic               accept;
  logic               issue_fire;
  logic               wait_fire;

  // armed_q keeps in_ready low until the first cycle after reset release
  assign in_ready   = armed_q && (state_q == FILL);
  assign core_init  = init_q;
  assign core_next  = next_q;
  assign core_mode  = MODE;
  assign core_block = blk_q;
  assign msg_done   = done_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FILL;
      after_q <= AFTER_FILL;
    end else begin
      state_q <= state_d;
      after_q <= after_d;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    state_d    = state_q;
    after_d    = after_q;
    accept     = 1'b0;
    issue_fire = 1'b0;
    wait_fire  = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          accept = 1'b1;
          // A full block is flushed first; padding of a last byte in slot 63
          // then starts the following block.
          if (idx_q == LAST_IDX) begin
            state_d = ISSUE;
            after_d = in_last ? AFTER_PAD : AFTER_FILL;
          end else if (in_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        if (idx_q == LAST_IDX) begin
          state_d = ISSUE;
          after_d = AFTER_ZERO;
        end else begin
          state_d = ZERO;
        end
      end
      ZERO: begin
        if (idx_q == LEN_IDX) begin
          state_d = LEN;
        end else if (idx_q == LAST_IDX) begin
          state_d = ISSUE;
          after_d = AFTER_ZERO;
        end
      end
      LEN: begin
        state_d = ISSUE;
        after_d = AFTER_DONE;
      end
      ISSUE: begin
        if (core_ready) begin
          issue_fire = 1'b1;
          state_d    = DROP;
        end
      end
      DROP: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (core_ready) begin
          wait_fire = 1'b1;
          case (after_q)
            AFTER_PAD:  state_d = PAD;
            AFTER_ZERO: state_d = ZERO;
            default:    state_d = FILL;
          endcase
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Block buffer, byte index, bit length and core handshake pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blk_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      first_q <= 1'b1;
      armed_q <= 1'b0;
      init_q  <= 1'b0;
      next_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      init_q  <= 1'b0;
      next_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
            blk_q[slot_msb(idx_q) -: 8] <= in_data;
            idx_q <= idx_q + 6'd1;
            len_q <= len_q + LEN_W'(8);
          end
        end
        PAD: begin
          blk_q[slot_msb(idx_q) -: 8] <= PAD_BYTE;
          idx_q <= idx_q + 6'd1;
        end
        ZERO: begin
          if (idx_q != LEN_IDX) begin
            blk_q[slot_msb(idx_q) -: 8] <= 8'h00;
            idx_q <= idx_q + 6'd1;
          end
        end
        LEN: begin
          blk_q[63:0] <= 64'(len_q);
        end
        ISSUE: begin
          if (issue_fire) begin
            init_q  <= first_q;
            next_q  <= !first_q;
            first_q <= 1'b0;
          end
        end
        WAIT: begin
          if (wait_fire) begin
            blk_q <= '0;
            idx_q <= '0;
            if (after_q == AFTER_DONE) begin
              done_q  <= 1'b1;
              len_q   <= '0;
              first_q <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SHA256_PADDER_BLKCNT_EN
  logic [15:0] cnt_q;

  // Blocks issued for the current message, saturating, cleared at message end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (wait_fire && (after_q == AFTER_DONE)) begin
      cnt_q <= '0;
    end else if (issue_fire && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign blk_cnt = cnt_q;
`else
  assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - directed self-checking bench for sha256_padder
module tb_sha256_padder;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         core_init;
  logic         core_next;
  logic         core_mode;
  logic [511:0] core_block;
  logic         core_ready;
  logic         msg_done;
  logic [15:0]  blk_cnt;

  int n_checks;
  int n_fail;

  logic [511:0] blocks[$];
  int           kinds[$];
  int           cnts[$];
  int           done_cnt;
  int           both_seen;
  int           hold;
  int           busy;
  logic [7:0]   msg[$];

  localparam logic [511:0] EXP_ROLAND = {56'h526f6c616e6480, 392'd0, 64'h30};
  localparam logic [511:0] EXP_ABC    = {32'h61626380, 416'd0, 64'h18};
  localparam logic [511:0] EXP_56_B1  = {{56{8'h61}}, 8'h80, 56'd0};
  localparam logic [511:0] EXP_56_B2  = {448'd0, 64'h1c0};
  localparam logic [511:0] EXP_55     = {{55{8'h61}}, 8'h80, 64'h1b8};
  localparam logic [511:0] EXP_64_B1  = {64{8'h61}};
  localparam logic [511:0] EXP_64_B2  = {8'h80, 440'd0, 64'h200};

`ifdef SHA256_PADDER_BLKCNT_EN
  localparam int EXP_CNT2 = 2;
`else
  localparam int EXP_CNT2 = 0;
`endif

  sha256_padder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .core_init  (core_init),
    .core_next  (core_next),
    .core_mode  (core_mode),
    .core_block (core_block),
    .core_ready (core_ready),
    .msg_done   (msg_done),
    .blk_cnt    (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core stand-in: records issued blocks, then drops ready for a few cycles
  initial begin
    core_ready = 1'b1;
    busy = 0;
    forever begin
      @(negedge clk);
      if (core_init && core_next) both_seen++;
      if (core_init || core_next) begin
        blocks.push_back(core_block);
        kinds.push_back(core_init ? 1 : 2);
        cnts.push_back(int'(blk_cnt));
        busy = 5;
      end
      if (msg_done) done_cnt++;
      if (busy > 0) busy--;
      core_ready = (busy == 0) && (hold == 0);
    end
  end

  task automatic clear_sb();
    blocks.delete();
    kinds.delete();
    cnts.delete();
    done_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check_eq("send_timeout", 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg();
    for (int i = 0; i < msg.size(); i++) send_byte(msg[i], i == msg.size() - 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (msg_done !== 1'b1 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check_eq("msg_done_seen", msg_done, 1'b1);
    repeat (8) @(negedge clk);
  endtask

  task automatic fill_msg(input int n, input logic [7:0] v);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(v);
  endtask

  task automatic load_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  initial begin
    int t;
    int rdy_hi;
    logic [511:0] snap;
    n_checks = 0;
    n_fail = 0;
    hold = 0;
    both_seen = 0;
    done_cnt = 0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_core_init", core_init, 1'b0);
    check_eq("rst_core_next", core_next, 1'b0);
    check_eq("rst_msg_done", msg_done, 1'b0);
    check_eq("rst_core_block", core_block, '0);
    check_eq("rst_blk_cnt", blk_cnt, 16'd0);
    check_eq("core_mode", core_mode, 1'b1);
    reset_n = 1'b1;
    check_eq("ready_before_edge", in_ready, 1'b0);
    @(negedge clk);
    check_eq("ready_after_release", in_ready, 1'b1);

    // "Roland"
    clear_sb();
    msg.delete();
    msg.push_back(8'h52); msg.push_back(8'h6f); msg.push_back(8'h6c);
    msg.push_back(8'h61); msg.push_back(8'h6e); msg.push_back(8'h64);
    send_msg();
    wait_done();
    check_eq("roland_nblk", blocks.size(), 1);
    if (blocks.size() == 1) begin
      check_eq("roland_block", blocks[0], EXP_ROLAND);
      check_eq("roland_kind", kinds[0], 1);
    end
    check_eq("roland_done_cnt", done_cnt, 1);

    // "abc"
    clear_sb();
    load_abc();
    send_msg();
    wait_done();
    check_eq("abc_nblk", blocks.size(), 1);
    if (blocks.size() == 1) check_eq("abc_block", blocks[0], EXP_ABC);

    // 55 bytes: last data in slot 54, still a single block
    clear_sb();
    fill_msg(55, 8'h61);
    send_msg();
    wait_done();
    check_eq("b55_nblk", blocks.size(), 1);
    if (blocks.size() == 1) check_eq("b55_block", blocks[0], EXP_55);

    // 56 bytes: length spills into a second block
    clear_sb();
    fill_msg(56, 8'h61);
    send_msg();
    wait_done();
    check_eq("b56_nblk", blocks.size(), 2);
    if (blocks.size() == 2) begin
      check_eq("b56_blk1", blocks[0], EXP_56_B1);
      check_eq("b56_blk2", blocks[1], EXP_56_B2);
      check_eq("b56_kind1", kinds[0], 1);
      check_eq("b56_kind2", kinds[1], 2);
      check_eq("b56_cnt2", cnts[1], EXP_CNT2);
    end
    check_eq("b56_cnt_cleared", blk_cnt, 16'd0);

    // 64 bytes: a full data block, then pad-only block; in_ready low meanwhile
    clear_sb();
    fill_msg(64, 8'h61);
    send_msg();
    rdy_hi = 0;
    t = 0;
    while (msg_done !== 1'b1 && t < 4000) begin
      if (in_ready) rdy_hi++;
      @(negedge clk);
      t++;
    end
    check_eq("b64_done_seen", msg_done, 1'b1);
    check_eq("b64_ready_low", rdy_hi, 0);
    check_eq("b64_ready_back", in_ready, 1'b1);
    repeat (8) @(negedge clk);
    check_eq("b64_nblk", blocks.size(), 2);
    if (blocks.size() == 2) begin
      check_eq("b64_blk1", blocks[0], EXP_64_B1);
      check_eq("b64_blk2", blocks[1], EXP_64_B2);
    end

    // core_ready held low in ISSUE: no pulse, block held
    clear_sb();
    hold = 1;
    repeat (2) @(negedge clk);
    load_abc();
    send_msg();
    repeat (60) @(negedge clk);
    snap = core_block;
    repeat (20) @(negedge clk);
    check_eq("hold_no_pulse", kinds.size(), 0);
    check_eq("hold_block_stable", core_block, snap);
    check_eq("hold_block_value", core_block, EXP_ABC);
    hold = 0;
    t = 0;
    while (t < 10) begin
      @(negedge clk);
      #1;
      if (core_ready) break;
      t++;
    end
    @(negedge clk);
    check_eq("hold_init_pulse", core_init, 1'b1);
    check_eq("hold_next_low", core_next, 1'b0);
    wait_done();
    check_eq("hold_nblk", blocks.size(), 1);

    // Reset mid-message aborts it
    clear_sb();
    for (int i = 0; i < 10; i++) send_byte(8'h55, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("abort_ready_low", in_ready, 1'b0);
    check_eq("abort_block_clr", core_block, '0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("abort_ready_back", in_ready, 1'b1);
    repeat (100) @(negedge clk);
    check_eq("abort_no_pulse", kinds.size(), 0);
    load_abc();
    send_msg();
    wait_done();
    check_eq("abort_abc_nblk", blocks.size(), 1);
    if (blocks.size() == 1) begin
      check_eq("abort_abc_block", blocks[0], EXP_ABC);
      check_eq("abort_abc_kind", kinds[0], 1);
    end

    check_eq("init_next_exclusive", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
